// File: rtl/stitch_seq_arbiter.sv
// Round-robin arbiter sharing one FPU sequencer input port among NumReq requesters.
// Loop (FREP/IREP) bodies are kept contiguous by locking the grant onto the issuing requester.
module stitch_seq_arbiter #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned Depth      = 16,
    parameter type         acc_addr_e = logic [1:0],
    localparam int unsigned DepthBits = $clog2(Depth),
    localparam int unsigned IdxBits   = $clog2(NumReq)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  acc_addr_e            inp_qaddr_i      [NumReq],
    input  logic [4:0]           inp_qid_i        [NumReq],
    input  logic [31:0]          inp_qdata_op_i   [NumReq],
    input  logic [DataWidth-1:0] inp_qdata_arga_i [NumReq],
    input  logic [DataWidth-1:0] inp_qdata_argb_i [NumReq],
    input  logic [AddrWidth-1:0] inp_qdata_argc_i [NumReq],
    input  logic [NumReq-1:0]    inp_qvalid_i,
    output logic [NumReq-1:0]    inp_qready_o,
    output acc_addr_e            oup_qaddr_o,
    output logic [4:0]           oup_qid_o,
    output logic [31:0]          oup_qdata_op_o,
    output logic [DataWidth-1:0] oup_qdata_arga_o,
    output logic [DataWidth-1:0] oup_qdata_argb_o,
    output logic [AddrWidth-1:0] oup_qdata_argc_o,
    output logic                 oup_qvalid_o,
    input  logic                 oup_qready_i,
    output logic [IdxBits-1:0]   oup_src_o,
    output logic                 lock_o
);

    localparam int unsigned RemBits = DepthBits + 2;

    // Match/mask pairs of the FREP_O, FREP_I and IREP encodings.
    localparam logic [31:0] MASK_FREP    = 32'h0000_00FF;
    localparam logic [31:0] MATCH_FREP_O = 32'h0000_000B;
    localparam logic [31:0] MATCH_FREP_I = 32'h0000_008B;
    localparam logic [31:0] MASK_IREP    = 32'h0000_007F;
    localparam logic [31:0] MATCH_IREP   = 32'h0000_003F;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e             state_q, state_d;
    logic [IdxBits-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxBits-1:0] lock_idx_q, lock_idx_d;
    logic [IdxBits-1:0] hold_idx_q, hold_idx_d;
    logic [RemBits-1:0] remain_q, remain_d;
    logic               hold_q, hold_d;

    logic [IdxBits-1:0] grant;
    logic [RemBits-1:0] body_len;
    logic [RemBits:0]   remain_sum;
    logic               is_loop;
    logic               accept;

    function automatic logic [IdxBits-1:0] wrap_inc(input logic [IdxBits-1:0] idx);
        return (32'(idx) == NumReq - 1) ? '0 : idx + IdxBits'(1);
    endfunction

    // Scan from farthest to nearest so the nearest valid requester at or after rr_ptr wins.
    always_comb begin
        grant = rr_ptr_q;
        if (state_q == LOCK) begin
            grant = lock_idx_q;
        end else if (hold_q) begin
            grant = hold_idx_q;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (inp_qvalid_i[IdxBits'((32'(rr_ptr_q) + NumReq - 1 - i) % NumReq)]) begin
                    grant = IdxBits'((32'(rr_ptr_q) + NumReq - 1 - i) % NumReq);
                end
            end
        end
    end

    always_comb begin
        oup_qaddr_o         = inp_qaddr_i[grant];
        oup_qid_o           = inp_qid_i[grant];
        oup_qdata_op_o      = inp_qdata_op_i[grant];
        oup_qdata_arga_o    = inp_qdata_arga_i[grant];
        oup_qdata_argb_o    = inp_qdata_argb_i[grant];
        oup_qdata_argc_o    = inp_qdata_argc_i[grant];
        oup_qvalid_o        = inp_qvalid_i[grant];
        inp_qready_o        = '0;
        inp_qready_o[grant] = oup_qready_i;
        oup_src_o           = grant;
        lock_o              = (state_q == LOCK);
    end

    assign accept   = oup_qvalid_o & oup_qready_i;
    assign is_loop  = ((oup_qdata_op_o & MASK_FREP) == MATCH_FREP_O)
                    | ((oup_qdata_op_o & MASK_FREP) == MATCH_FREP_I)
                    | ((oup_qdata_op_o & MASK_IREP) == MATCH_IREP);
    assign body_len = RemBits'(oup_qdata_op_o[20 +: DepthBits]) + RemBits'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        remain_d   = remain_q;
        hold_d     = oup_qvalid_o & ~oup_qready_i;
        hold_idx_d = hold_d ? grant : hold_idx_q;
        remain_sum = {1'b0, remain_q} + {1'b0, body_len};
        if (accept) begin
            if (state_q == IDLE) begin
                rr_ptr_d = wrap_inc(grant);
                if (is_loop) begin
                    state_d    = LOCK;
                    lock_idx_d = grant;
                    remain_d   = body_len;
                end
            end else if (is_loop) begin
                remain_d = remain_sum[RemBits] ? '1 : remain_sum[RemBits-1:0];
            end else begin
                remain_d = remain_q - RemBits'(1);
                if (remain_q == RemBits'(1)) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(lock_idx_q);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            remain_q   <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            remain_q   <= remain_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // A requester whose stalled request is being held must keep it valid.
    hold_valid_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                   hold_q |-> inp_qvalid_i[hold_idx_q]);

endmodule

// File: tb/tb_stitch_seq_arbiter.sv
// Scoreboard bench for stitch_seq_arbiter: directed lock/stall/reset sequences followed by
// randomised traffic, predicted by a requester-level reference model.
`timescale 1ns/1ps
module tb_stitch_seq_arbiter;

    localparam int NumReq = 2;
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int PW     = 2 + 5 + DW + DW + AW;
    localparam int RemMax = 63;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        qaddr [NumReq];
    logic [4:0]        qid   [NumReq];
    logic [31:0]       op    [NumReq];
    logic [DW-1:0]     arga  [NumReq];
    logic [DW-1:0]     argb  [NumReq];
    logic [AW-1:0]     argc  [NumReq];
    logic [NumReq-1:0] qvalid;
    logic [NumReq-1:0] qready;
    logic [1:0]        oup_qaddr_o;
    logic [4:0]        oup_qid_o;
    logic [31:0]       oup_qdata_op_o;
    logic [DW-1:0]     oup_qdata_arga_o;
    logic [DW-1:0]     oup_qdata_argb_o;
    logic [AW-1:0]     oup_qdata_argc_o;
    logic              oup_qvalid_o;
    logic              oup_qready_i;
    logic [0:0]        oup_src_o;
    logic              lock_o;

    stitch_seq_arbiter #(
        .NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW), .Depth(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inp_qaddr_i(qaddr), .inp_qid_i(qid), .inp_qdata_op_i(op),
        .inp_qdata_arga_i(arga), .inp_qdata_argb_i(argb), .inp_qdata_argc_i(argc),
        .inp_qvalid_i(qvalid), .inp_qready_o(qready),
        .oup_qaddr_o(oup_qaddr_o), .oup_qid_o(oup_qid_o), .oup_qdata_op_o(oup_qdata_op_o),
        .oup_qdata_arga_o(oup_qdata_arga_o), .oup_qdata_argb_o(oup_qdata_argb_o),
        .oup_qdata_argc_o(oup_qdata_argc_o), .oup_qvalid_o(oup_qvalid_o),
        .oup_qready_i(oup_qready_i), .oup_src_o(oup_src_o), .lock_o(lock_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              src;
        logic [31:0]     op;
        logic [PW-1:0]   payload;
        logic            lock;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lock_accepts = 0;

    // Reference model: requester-level view of who owns the port.
    int   m_rr, m_owner, m_remain, m_hold_idx;
    bit   m_locked, m_hold;

    task automatic compare(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] payload_of(input int i, input logic [31:0] o);
        logic [1:0]    a;
        logic [4:0]    d;
        logic [DW-1:0] x, y;
        logic [AW-1:0] z;
        a = o[9:8] ^ 2'(i);
        d = o[15:11] ^ 5'(i);
        x = {o, ~o} ^ 64'(i);
        y = {o[15:0], o, o[31:16]};
        z = o ^ 32'hA5A5_0000 ^ 32'(i);
        return {a, d, x, y, z};
    endfunction

    function automatic bit is_loop_op(input logic [31:0] o);
        return (o[6:0] == 7'b0001011) || (o[6:0] == 7'b0111111);
    endfunction

    function automatic int body_len(input logic [31:0] o);
        return int'(o[23:20]) + 1;
    endfunction

    function automatic logic [31:0] plain_op();
        logic [31:0] r;
        r = $urandom;
        r[6:0] = 7'h53;
        return r;
    endfunction

    function automatic logic [31:0] loop_op(input int kind, input int max_inst);
        logic [31:0] r;
        r = $urandom;
        r[23:20] = 4'(max_inst);
        if (kind == 0)      r[7:0] = 8'h0B;
        else if (kind == 1) r[7:0] = 8'h8B;
        else                r[6:0] = 7'h3F;
        return r;
    endfunction

    task automatic set_req(input int i, input logic [31:0] o);
        op[i] = o;
        {qaddr[i], qid[i], arga[i], argb[i], argc[i]} = payload_of(i, o);
    endtask

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_remain = 0; m_hold_idx = 0;
        m_locked = 0; m_hold = 0;
    endtask

    task automatic checkOutput(input int g, input logic v, input logic rdy);
        logic [NumReq-1:0] exp_rdy;
        exp_rdy = '0;
        exp_rdy[g] = rdy;
        compare("src", 256'(oup_src_o), 256'(g));
        compare("qvalid", 256'(oup_qvalid_o), 256'(v));
        compare("inp_qready", 256'(qready), 256'(exp_rdy));
        compare("lock", 256'(lock_o), 256'(m_locked));
        if (v) compare("op_mux", 256'(oup_qdata_op_o), 256'(op[g]));
    endtask

    // One clock cycle: drive, predict, check the combinational response, queue any acceptance.
    task automatic applyStimulus(input logic [NumReq-1:0] vin, input logic [31:0] op0,
                                 input logic [31:0] op1, input logic rdy, input logic rst,
                                 output int acc_idx);
        int   g;
        bit   found;
        logic v;
        exp_t e;
        @(negedge clk_i);
        rst_i = rst;
        qvalid = vin;
        oup_qready_i = rdy;
        set_req(0, op0);
        set_req(1, op1);
        #1;
        g = m_rr;
        if (m_locked) g = m_owner;
        else if (m_hold) g = m_hold_idx;
        else begin
            found = 0;
            for (int k = 0; k < NumReq; k++) begin
                if (!found && vin[(m_rr + k) % NumReq]) begin
                    g = (m_rr + k) % NumReq;
                    found = 1;
                end
            end
        end
        v = vin[g];
        checkOutput(g, v, rdy);
        acc_idx = -1;
        if (v && rdy) begin
            e.src = g;
            e.op = op[g];
            e.payload = payload_of(g, op[g]);
            e.lock = m_locked;
            sb_q.push_back(e);
            acc_idx = g;
        end
        if (rst) begin
            model_reset();
        end else begin
            m_hold = v && !rdy;
            if (m_hold) m_hold_idx = g;
            if (v && rdy) begin
                if (!m_locked) begin
                    m_rr = (g + 1) % NumReq;
                    if (is_loop_op(op[g])) begin
                        m_locked = 1;
                        m_owner = g;
                        m_remain = body_len(op[g]);
                    end
                end else if (is_loop_op(op[g])) begin
                    m_remain = (m_remain + body_len(op[g]) > RemMax) ? RemMax
                                                                     : m_remain + body_len(op[g]);
                end else begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_locked = 0;
                        m_rr = (m_owner + 1) % NumReq;
                    end
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, independent of the stimulus.
    always begin
        @(negedge clk_i);
        #4;
        if (oup_qvalid_o === 1'b1 && oup_qready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL sb_unexpected: accept from src %0d with nothing expected", oup_src_o);
            end else begin
                mon_e = sb_q.pop_front();
                compare("sb_src", 256'(oup_src_o), 256'(mon_e.src));
                compare("sb_op", 256'(oup_qdata_op_o), 256'(mon_e.op));
                compare("sb_payload", 256'({oup_qaddr_o, oup_qid_o, oup_qdata_arga_o,
                                            oup_qdata_argb_o, oup_qdata_argc_o}),
                        256'(mon_e.payload));
                compare("sb_lock", 256'(lock_o), 256'(mon_e.lock));
                if (lock_o) lock_accepts++;
            end
        end
    end

    initial begin
        int          a;
        logic [31:0] s0, s1;
        logic [31:0] cur_op [NumReq];
        bit          cur_v  [NumReq];

        rst_i = 1'b1;
        qvalid = '0;
        oup_qready_i = 1'b0;
        set_req(0, 32'h0);
        set_req(1, 32'h0);
        repeat (2) @(posedge clk_i);
        model_reset();

        applyStimulus(2'b00, plain_op(), plain_op(), 1'b0, 1'b0, a);
        compare("reset_src", 256'(oup_src_o), 256'(0));
        compare("reset_valid", 256'(oup_qvalid_o), 256'(0));
        compare("reset_lock", 256'(lock_o), 256'(0));

        $display("[TB] lock contiguity");
        lock_accepts = 0;
        applyStimulus(2'b11, loop_op(0, 2), plain_op(), 1'b1, 1'b0, a);
        for (int k = 0; k < 3; k++) applyStimulus(2'b11, plain_op(), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b10, plain_op(), plain_op(), 1'b1, 1'b0, a);
        compare("contig_src1", 256'(oup_src_o), 256'(1));
        compare("contig_lock_accepts", 256'(lock_accepts), 256'(3));

        $display("[TB] fairness");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2'b11, plain_op(), plain_op(), 1'b1, 1'b0, a);
            compare("fair_src", 256'(oup_src_o), 256'(k % 2));
        end

        $display("[TB] stall hold");
        applyStimulus(2'b01, plain_op(), plain_op(), 1'b1, 1'b0, a);
        s0 = plain_op();
        s1 = plain_op();
        for (int k = 0; k < 5; k++) begin
            applyStimulus((k >= 2) ? 2'b11 : 2'b10, s0, s1, 1'b0, 1'b0, a);
            compare("stall_src", 256'(oup_src_o), 256'(1));
            compare("stall_data", 256'(oup_qdata_arga_o), 256'(arga[1]));
        end
        applyStimulus(2'b11, s0, s1, 1'b1, 1'b0, a);
        compare("stall_release_src", 256'(oup_src_o), 256'(1));
        applyStimulus(2'b01, s0, plain_op(), 1'b1, 1'b0, a);
        compare("stall_next_src", 256'(oup_src_o), 256'(0));

        $display("[TB] nested loop");
        lock_accepts = 0;
        applyStimulus(2'b01, loop_op(1, 3), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b01, plain_op(), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b01, loop_op(2, 1), plain_op(), 1'b1, 1'b0, a);
        for (int k = 0; k < 5; k++) applyStimulus(2'b01, plain_op(), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b00, plain_op(), plain_op(), 1'b1, 1'b0, a);
        compare("nested_lock_accepts", 256'(lock_accepts), 256'(7));
        compare("nested_idle", 256'(lock_o), 256'(0));

        $display("[TB] max length");
        lock_accepts = 0;
        applyStimulus(2'b01, loop_op(0, 15), plain_op(), 1'b1, 1'b0, a);
        for (int k = 0; k < 16; k++) applyStimulus(2'b01, plain_op(), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b00, plain_op(), plain_op(), 1'b1, 1'b0, a);
        compare("max_lock_accepts", 256'(lock_accepts), 256'(16));
        compare("max_lock_fall", 256'(lock_o), 256'(0));

        $display("[TB] reset mid-lock");
        applyStimulus(2'b01, loop_op(0, 3), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b01, plain_op(), plain_op(), 1'b1, 1'b0, a);
        applyStimulus(2'b00, plain_op(), plain_op(), 1'b1, 1'b1, a);
        applyStimulus(2'b11, plain_op(), plain_op(), 1'b1, 1'b0, a);
        compare("rstlock_src", 256'(oup_src_o), 256'(0));
        compare("rstlock_lock", 256'(lock_o), 256'(0));

        $display("[TB] random traffic");
        for (int i = 0; i < NumReq; i++) begin
            cur_v[i] = 0;
            cur_op[i] = plain_op();
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!cur_v[i] && $urandom_range(1, 0) == 1) begin
                    cur_v[i] = 1;
                    if ($urandom_range(7, 0) == 0)
                        cur_op[i] = loop_op($urandom_range(2, 0),
                                            ($urandom_range(9, 0) == 0) ? 15 : $urandom_range(3, 0));
                    else
                        cur_op[i] = plain_op();
                end
            end
            applyStimulus({cur_v[1], cur_v[0]}, cur_op[0], cur_op[1],
                          ($urandom_range(3, 0) != 0), 1'b0, a);
            if (a >= 0) cur_v[a] = 0;
        end

        #5;
        compare("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
